// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT spectrum peak-detect slice.
package fft_pkg;
  localparam int WIDTH   = 24;
  localparam int log2NUM = 4;
  localparam int NUM     = 2**log2NUM;
  localparam int MAG_W   = 2*WIDTH+1;

  typedef logic signed [WIDTH-1:0] sample_t;
  typedef logic [2*WIDTH-1:0]      sq_t;
  typedef logic [MAG_W-1:0]        mag_t;
  typedef logic [log2NUM-1:0]      idx_t;

  // The square of a signed sample is never negative and never exceeds 2^(2W-2),
  // so the low 2W bits of the widened product are the exact unsigned result.
  function automatic sq_t square(input sample_t x);
    logic signed [2*WIDTH-1:0] xw;
    xw = x;
    return sq_t'(xw * xw);
  endfunction
endpackage

// File: rtl/fft_peak_detect_if.sv
// Stream bundle between the bit-reversal sort stage, the peak detector and its consumer.
// Optional macro PEAK_THRESH_EN adds the threshold input and the peak_hit flag.
interface fft_peak_detect_if;
  import fft_pkg::*;

  logic    din_valid;
  sample_t din_r;
  sample_t din_i;
  logic    mag_valid;
  mag_t    mag;
  idx_t    mag_idx;
  logic    peak_valid;
  idx_t    peak_idx;
  mag_t    peak_mag;
`ifdef PEAK_THRESH_EN
  mag_t    thresh;
  logic    peak_hit;

  modport master (output din_valid, din_r, din_i, thresh,
                  input  mag_valid, mag, mag_idx, peak_valid, peak_idx, peak_mag, peak_hit);
  modport slave  (input  din_valid, din_r, din_i, thresh,
                  output mag_valid, mag, mag_idx, peak_valid, peak_idx, peak_mag, peak_hit);
`else
  modport master (output din_valid, din_r, din_i,
                  input  mag_valid, mag, mag_idx, peak_valid, peak_idx, peak_mag);
  modport slave  (input  din_valid, din_r, din_i,
                  output mag_valid, mag, mag_idx, peak_valid, peak_idx, peak_mag);
`endif
endinterface

// File: rtl/fft_peak_detect_mag_sq.sv
// Two-stage magnitude-squared pipeline carrying a valid and a bin-index sideband.
module mag_sq
  import fft_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    clear,
  input  logic    in_valid,
  input  sample_t in_r,
  input  sample_t in_i,
  input  idx_t    in_idx,
  output logic    out_valid,
  output mag_t    out_mag,
  output idx_t    out_idx
);
  logic vld_p1;
  sq_t  sq_r_p1;
  sq_t  sq_i_p1;
  idx_t idx_p1;
  logic vld_p2;
  mag_t mag_p2;
  idx_t idx_p2;

  // Stage 1: independent squares of the real and imaginary parts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      sq_r_p1 <= '0;
      sq_i_p1 <= '0;
      idx_p1  <= '0;
    end else begin
      vld_p1 <= in_valid & ~clear;
      if (in_valid) begin
        sq_r_p1 <= square(in_r);
        sq_i_p1 <= square(in_i);
        idx_p1  <= in_idx;
      end
    end
  end

  // Stage 2: one extra bit holds the worst case 2^(2W-1) without saturation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p2 <= 1'b0;
      mag_p2 <= '0;
      idx_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1 & ~clear;
      if (vld_p1) begin
        mag_p2 <= {1'b0, sq_r_p1} + {1'b0, sq_i_p1};
        idx_p2 <= idx_p1;
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_mag   = mag_p2;
  assign out_idx   = idx_p2;
endmodule

// File: rtl/fft_peak_detect.sv
// Per-bin magnitude-squared stream plus once-per-frame peak bin/magnitude report.
// Optional macro PEAK_THRESH_EN adds a registered peak_hit = (peak_mag > thresh).
module fft_peak_detect
  import fft_pkg::*;
(
  input logic              clk,
  input logic              rst,
  input logic              clear,
  fft_peak_detect_if.slave bus
);
  idx_t bin_cnt;
  logic vld_p2;
  mag_t mag_p2;
  idx_t idx_p2;
  mag_t run_max;
  idx_t run_idx;
  mag_t next_max;
  idx_t next_idx;
  logic last_bin;
  logic peak_valid_p3;
  idx_t peak_idx_p3;
  mag_t peak_mag_p3;

  // A cleared cycle drops its sample, so the counter restarts at bin 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               bin_cnt <= '0;
    else if (clear)         bin_cnt <= '0;
    else if (bus.din_valid) bin_cnt <= bin_cnt + 1'b1;
  end

  mag_sq u_mag_sq (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (bus.din_valid),
    .in_r      (bus.din_r),
    .in_i      (bus.din_i),
    .in_idx    (bin_cnt),
    .out_valid (vld_p2),
    .out_mag   (mag_p2),
    .out_idx   (idx_p2)
  );

  // Strict compare keeps the lowest index on ties; bin 0 always reloads.
  always_comb begin
    next_max = run_max;
    next_idx = run_idx;
    if (idx_p2 == '0 || mag_p2 > run_max) begin
      next_max = mag_p2;
      next_idx = idx_p2;
    end
  end

  assign last_bin = vld_p2 && (idx_p2 == idx_t'(NUM-1));

`ifdef PEAK_THRESH_EN
  logic peak_hit_p3;
`endif

  // Stage 3: running maximum and frame-end report
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_max       <= '0;
      run_idx       <= '0;
      peak_valid_p3 <= 1'b0;
      peak_idx_p3   <= '0;
      peak_mag_p3   <= '0;
`ifdef PEAK_THRESH_EN
      peak_hit_p3   <= 1'b0;
`endif
    end else if (clear) begin
      run_max       <= '0;
      run_idx       <= '0;
      peak_valid_p3 <= 1'b0;
    end else begin
      peak_valid_p3 <= last_bin;
      if (vld_p2) begin
        run_max <= next_max;
        run_idx <= next_idx;
      end
      if (last_bin) begin
        peak_idx_p3 <= next_idx;
        peak_mag_p3 <= next_max;
`ifdef PEAK_THRESH_EN
        peak_hit_p3 <= (next_max > bus.thresh);
`endif
      end
    end
  end

  assign bus.mag_valid  = vld_p2;
  assign bus.mag        = mag_p2;
  assign bus.mag_idx    = idx_p2;
  assign bus.peak_valid = peak_valid_p3;
  assign bus.peak_idx   = peak_idx_p3;
  assign bus.peak_mag   = peak_mag_p3;
`ifdef PEAK_THRESH_EN
  assign bus.peak_hit   = peak_hit_p3;
`endif
endmodule

// File: tb/tb_fft_peak_detect.sv
// Self-checking bench for fft_peak_detect against a frame-level reference model.
module tb_fft_peak_detect;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;

  fft_peak_detect_if bus ();
  fft_peak_detect dut (.clk(clk), .rst(rst), .clear(clear), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic mv; mag_t mag; idx_t midx;
    logic pv; idx_t pidx; mag_t pmag; logic hit;
  } rec_t;

  rec_t obs_q[$];
  rec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   bin = 0;
  mag_t frame_mag[NUM];
  mag_t ev_mag[int];
  idx_t ev_midx[int];
  mag_t ev_pmag[int];
  idx_t ev_pidx[int];
  logic ev_hit[int];
  idx_t cur_pidx = '0;
  mag_t cur_pmag = '0;
  logic cur_hit = 1'b0;
  mag_t thr = '0;

  // One clock of stimulus; the model predicts outputs from frame-level rules.
  task automatic run_cycle(input logic v, input int r, input int i, input logic clr);
    rec_t e, o;
    mag_t m;
    int   best;
    bus.din_valid = v;
    bus.din_r     = sample_t'(r);
    bus.din_i     = sample_t'(i);
    clear         = clr;
`ifdef PEAK_THRESH_EN
    bus.thresh    = thr;
`endif
    e.mv   = ev_mag.exists(cyc);
    e.mag  = e.mv ? ev_mag[cyc] : '0;
    e.midx = e.mv ? ev_midx[cyc] : '0;
    e.pv   = ev_pmag.exists(cyc);
    if (e.pv) begin
      cur_pmag = ev_pmag[cyc];
      cur_pidx = ev_pidx[cyc];
      cur_hit  = ev_hit[cyc];
    end
    e.pidx = cur_pidx;
    e.pmag = cur_pmag;
    e.hit  = cur_hit;
    if (clr) begin
      for (int d = 1; d <= 3; d++) begin
        if (ev_mag.exists(cyc+d))  begin ev_mag.delete(cyc+d);  ev_midx.delete(cyc+d); end
        if (ev_pmag.exists(cyc+d)) begin ev_pmag.delete(cyc+d); ev_pidx.delete(cyc+d); ev_hit.delete(cyc+d); end
      end
      bin = 0;
    end else if (v) begin
      m = mag_t'(longint'(r) * longint'(r) + longint'(i) * longint'(i));
      frame_mag[bin] = m;
      ev_mag[cyc+2]  = m;
      ev_midx[cyc+2] = idx_t'(bin);
      if (bin == NUM-1) begin
        best = 0;
        for (int k = 1; k < NUM; k++) if (frame_mag[k] > frame_mag[best]) best = k;
        ev_pmag[cyc+3] = frame_mag[best];
        ev_pidx[cyc+3] = idx_t'(best);
        ev_hit[cyc+3]  = frame_mag[best] > thr;
      end
      bin = (bin + 1) % NUM;
    end
    @(negedge clk);
    o.mv = bus.mag_valid;  o.mag = bus.mag;       o.midx = bus.mag_idx;
    o.pv = bus.peak_valid; o.pidx = bus.peak_idx; o.pmag = bus.peak_mag;
`ifdef PEAK_THRESH_EN
    o.hit = bus.peak_hit;
`else
    o.hit = 1'b0;
`endif
    obs_q.push_back(o);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) run_cycle(1'b0, 0, 0, 1'b0);
  endtask

  // Bin k = (k, 0) except bin 9 = (100, -100); optional random 1-4 cycle gaps.
  task automatic drive_basic(input logic gaps, output int last_j);
    for (int k = 0; k < NUM; k++) begin
      if (gaps && k != 0) idle($urandom_range(1, 4));
      last_j = obs_q.size();
      if (k == 9) run_cycle(1'b1, 100, -100, 1'b0);
      else        run_cycle(1'b1, k, 0, 1'b0);
    end
  endtask

  function automatic int rnd_sample();
    return $signed($urandom) >>> 8;
  endfunction

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if ({bus.mag_valid, bus.mag, bus.mag_idx} !== '0) begin
      n_err++; $display("FAIL reset mag outputs: got %b/%h/%h want 0", bus.mag_valid, bus.mag, bus.mag_idx);
    end
    n_vec++;
    if ({bus.peak_valid, bus.peak_idx, bus.peak_mag} !== '0) begin
      n_err++; $display("FAIL reset peak outputs: got %b/%h/%h want 0", bus.peak_valid, bus.peak_idx, bus.peak_mag);
    end
`ifdef PEAK_THRESH_EN
    n_vec++;
    if (bus.peak_hit !== 1'b0) begin n_err++; $display("FAIL reset peak_hit: got %b want 0", bus.peak_hit); end
`endif
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_basic();
    int last;
    drive_basic(1'b0, last);
    idle(5);
    foreach (obs_q[j]) begin
      n_vec++;
      if (obs_q[j].mv !== exp_q[j].mv) begin n_err++; $display("FAIL basic mag_valid c%0d: got %b want %b", j, obs_q[j].mv, exp_q[j].mv); end
      if (exp_q[j].mv === 1'b1) begin
        n_vec++;
        if ({obs_q[j].midx, obs_q[j].mag} !== {exp_q[j].midx, exp_q[j].mag}) begin
          n_err++; $display("FAIL basic mag c%0d: got %0d/%0d want %0d/%0d", j, obs_q[j].midx, obs_q[j].mag, exp_q[j].midx, exp_q[j].mag);
        end
      end
      n_vec++;
      if ({obs_q[j].pv, obs_q[j].pidx, obs_q[j].pmag} !== {exp_q[j].pv, exp_q[j].pidx, exp_q[j].pmag}) begin
        n_err++; $display("FAIL basic peak c%0d: got %b/%0d/%0d want %b/%0d/%0d", j, obs_q[j].pv, obs_q[j].pidx, obs_q[j].pmag, exp_q[j].pv, exp_q[j].pidx, exp_q[j].pmag);
      end
    end
    n_vec++;
    if (obs_q[11].mv !== 1'b1 || obs_q[11].mag !== mag_t'(20000)) begin
      n_err++; $display("FAIL basic bin9 mag: got %b/%0d want 1/20000", obs_q[11].mv, obs_q[11].mag);
    end
    n_vec++;
    if (obs_q[last+3].pv !== 1'b1 || obs_q[last+3].pidx !== idx_t'(9) || obs_q[last+3].pmag !== mag_t'(20000)) begin
      n_err++; $display("FAIL basic peak report: got %b/%0d/%0d want 1/9/20000", obs_q[last+3].pv, obs_q[last+3].pidx, obs_q[last+3].pmag);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_extreme();
    mag_t big;
    big = mag_t'(1) << 47;
    run_cycle(1'b1, -8388608, -8388608, 1'b0);
    run_cycle(1'b1, 8388607, -8388608, 1'b0);
    for (int k = 2; k < NUM; k++) run_cycle(1'b1, rnd_sample(), rnd_sample(), 1'b0);
    idle(4);
    foreach (obs_q[j]) begin
      n_vec++;
      if ({obs_q[j].mv, obs_q[j].midx, obs_q[j].mag} !== {exp_q[j].mv, exp_q[j].midx, exp_q[j].mag} && exp_q[j].mv === 1'b1) begin
        n_err++; $display("FAIL extreme mag c%0d: got %b/%0d/%h want %b/%0d/%h", j, obs_q[j].mv, obs_q[j].midx, obs_q[j].mag, exp_q[j].mv, exp_q[j].midx, exp_q[j].mag);
      end
    end
    n_vec++;
    if (obs_q[2].mag !== big) begin n_err++; $display("FAIL extreme max square: got %h want %h", obs_q[2].mag, big); end
    n_vec++;
    if (obs_q[18].pv !== 1'b1 || obs_q[18].pidx !== idx_t'(0) || obs_q[18].pmag !== big) begin
      n_err++; $display("FAIL extreme peak: got %b/%0d/%h want 1/0/%h", obs_q[18].pv, obs_q[18].pidx, obs_q[18].pmag, big);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_tie();
    for (int k = 0; k < NUM; k++) begin
      if (k == 3 || k == 11) run_cycle(1'b1, 5, 5, 1'b0);
      else                   run_cycle(1'b1, 0, 0, 1'b0);
    end
    idle(4);
    foreach (obs_q[j]) begin
      n_vec++;
      if ({obs_q[j].pv, obs_q[j].pidx, obs_q[j].pmag} !== {exp_q[j].pv, exp_q[j].pidx, exp_q[j].pmag}) begin
        n_err++; $display("FAIL tie peak c%0d: got %b/%0d/%0d want %b/%0d/%0d", j, obs_q[j].pv, obs_q[j].pidx, obs_q[j].pmag, exp_q[j].pv, exp_q[j].pidx, exp_q[j].pmag);
      end
    end
    n_vec++;
    if (obs_q[18].pv !== 1'b1 || obs_q[18].pidx !== idx_t'(3) || obs_q[18].pmag !== mag_t'(50)) begin
      n_err++; $display("FAIL tie report: got %b/%0d/%0d want 1/3/50", obs_q[18].pv, obs_q[18].pidx, obs_q[18].pmag);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_gaps();
    int last;
    drive_basic(1'b1, last);
    idle(5);
    foreach (obs_q[j]) begin
      n_vec++;
      if (obs_q[j].mv !== exp_q[j].mv || (exp_q[j].mv === 1'b1 && {obs_q[j].midx, obs_q[j].mag} !== {exp_q[j].midx, exp_q[j].mag})) begin
        n_err++; $display("FAIL gaps mag c%0d: got %b/%0d/%0d want %b/%0d/%0d", j, obs_q[j].mv, obs_q[j].midx, obs_q[j].mag, exp_q[j].mv, exp_q[j].midx, exp_q[j].mag);
      end
      n_vec++;
      if (obs_q[j].pv !== exp_q[j].pv) begin n_err++; $display("FAIL gaps peak_valid c%0d: got %b want %b", j, obs_q[j].pv, exp_q[j].pv); end
    end
    n_vec++;
    if (obs_q[last+3].pv !== 1'b1 || obs_q[last+3].pidx !== idx_t'(9) || obs_q[last+3].pmag !== mag_t'(20000)) begin
      n_err++; $display("FAIL gaps peak report: got %b/%0d/%0d want 1/9/20000", obs_q[last+3].pv, obs_q[last+3].pidx, obs_q[last+3].pmag);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_clear();
    int last;
    for (int k = 0; k < 7; k++) run_cycle(1'b1, rnd_sample(), rnd_sample(), 1'b0);
    run_cycle(1'b1, 1000, 1000, 1'b1);
    clear = 1'b0;
    drive_basic(1'b0, last);
    idle(5);
    foreach (obs_q[j]) begin
      n_vec++;
      if (obs_q[j].mv !== exp_q[j].mv || (exp_q[j].mv === 1'b1 && {obs_q[j].midx, obs_q[j].mag} !== {exp_q[j].midx, exp_q[j].mag})) begin
        n_err++; $display("FAIL clear mag c%0d: got %b/%0d/%0d want %b/%0d/%0d", j, obs_q[j].mv, obs_q[j].midx, obs_q[j].mag, exp_q[j].mv, exp_q[j].midx, exp_q[j].mag);
      end
      n_vec++;
      if ({obs_q[j].pv, obs_q[j].pidx, obs_q[j].pmag} !== {exp_q[j].pv, exp_q[j].pidx, exp_q[j].pmag}) begin
        n_err++; $display("FAIL clear peak c%0d: got %b/%0d/%0d want %b/%0d/%0d", j, obs_q[j].pv, obs_q[j].pidx, obs_q[j].pmag, exp_q[j].pv, exp_q[j].pidx, exp_q[j].pmag);
      end
    end
    n_vec++;
    if (obs_q[8].mv !== 1'b0 || obs_q[10].mv !== 1'b1 || obs_q[10].midx !== idx_t'(0)) begin
      n_err++; $display("FAIL clear realign: got flushed=%b first=%b/%0d want 0 1/0", obs_q[8].mv, obs_q[10].mv, obs_q[10].midx);
    end
    n_vec++;
    if (obs_q[last+3].pv !== 1'b1 || obs_q[last+3].pidx !== idx_t'(9)) begin
      n_err++; $display("FAIL clear next frame: got %b/%0d want 1/9", obs_q[last+3].pv, obs_q[last+3].pidx);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_rst_mid();
    int last;
    for (int k = 0; k < 5; k++) run_cycle(1'b1, k + 7, k, 1'b0);
    rst = 1'b0;
    bus.din_valid = 1'b0;
    #1;
    n_vec++;
    if ({bus.mag_valid, bus.mag, bus.mag_idx, bus.peak_valid, bus.peak_idx, bus.peak_mag} !== '0) begin
      n_err++; $display("FAIL rst_mid outputs: got %b/%0d/%0d %b/%0d/%0d want all 0", bus.mag_valid, bus.mag, bus.mag_idx, bus.peak_valid, bus.peak_idx, bus.peak_mag);
    end
`ifdef PEAK_THRESH_EN
    n_vec++;
    if (bus.peak_hit !== 1'b0) begin n_err++; $display("FAIL rst_mid peak_hit: got %b want 0", bus.peak_hit); end
`endif
    ev_mag.delete(); ev_midx.delete(); ev_pmag.delete(); ev_pidx.delete(); ev_hit.delete();
    bin = 0; cur_pidx = '0; cur_pmag = '0; cur_hit = 1'b0;
    obs_q.delete(); exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    cyc++;
    drive_basic(1'b0, last);
    idle(5);
    foreach (obs_q[j]) begin
      n_vec++;
      if ({obs_q[j].mv, obs_q[j].pv, obs_q[j].pidx, obs_q[j].pmag} !== {exp_q[j].mv, exp_q[j].pv, exp_q[j].pidx, exp_q[j].pmag}) begin
        n_err++; $display("FAIL rst_mid c%0d: got %b %b/%0d/%0d want %b %b/%0d/%0d", j, obs_q[j].mv, obs_q[j].pv, obs_q[j].pidx, obs_q[j].pmag, exp_q[j].mv, exp_q[j].pv, exp_q[j].pidx, exp_q[j].pmag);
      end
    end
    n_vec++;
    if (obs_q[2].midx !== idx_t'(0) || obs_q[last+3].pidx !== idx_t'(9)) begin
      n_err++; $display("FAIL rst_mid realign: got first=%0d peak=%0d want 0/9", obs_q[2].midx, obs_q[last+3].pidx);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < NUM; k++) begin
        if (f == 3 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        run_cycle(1'b1, rnd_sample(), rnd_sample(), 1'b0);
      end
    idle(5);
    foreach (obs_q[j]) begin
      n_vec++;
      if (obs_q[j].mv !== exp_q[j].mv || (exp_q[j].mv === 1'b1 && {obs_q[j].midx, obs_q[j].mag} !== {exp_q[j].midx, exp_q[j].mag})) begin
        n_err++; $display("FAIL b2b mag c%0d: got %b/%0d/%h want %b/%0d/%h", j, obs_q[j].mv, obs_q[j].midx, obs_q[j].mag, exp_q[j].mv, exp_q[j].midx, exp_q[j].mag);
      end
      n_vec++;
      if ({obs_q[j].pv, obs_q[j].pidx, obs_q[j].pmag} !== {exp_q[j].pv, exp_q[j].pidx, exp_q[j].pmag}) begin
        n_err++; $display("FAIL b2b peak c%0d: got %b/%0d/%h want %b/%0d/%h", j, obs_q[j].pv, obs_q[j].pidx, obs_q[j].pmag, exp_q[j].pv, exp_q[j].pidx, exp_q[j].pmag);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

`ifdef PEAK_THRESH_EN
  task automatic test_thresh();
    int last;
    logic hit_a, hit_b;
    thr = mag_t'(19999);
    drive_basic(1'b0, last);
    idle(5);
    hit_a = obs_q[last+3].hit;
    thr = mag_t'(20000);
    drive_basic(1'b0, last);
    idle(5);
    hit_b = obs_q[last+3].hit;
    foreach (obs_q[j]) begin
      n_vec++;
      if ({obs_q[j].pv, obs_q[j].hit} !== {exp_q[j].pv, exp_q[j].hit}) begin
        n_err++; $display("FAIL thresh c%0d: got pv=%b hit=%b want pv=%b hit=%b", j, obs_q[j].pv, obs_q[j].hit, exp_q[j].pv, exp_q[j].hit);
      end
    end
    n_vec++;
    if (hit_a !== 1'b1 || hit_b !== 1'b0) begin
      n_err++; $display("FAIL thresh hit: got %b/%b want 1/0", hit_a, hit_b);
    end
    obs_q.delete(); exp_q.delete();
  endtask
`endif

  initial begin
    bus.din_valid = 1'b0;
    bus.din_r     = '0;
    bus.din_i     = '0;
`ifdef PEAK_THRESH_EN
    bus.thresh    = '0;
`endif
    test_reset();
    test_basic();
    test_extreme();
    test_tie();
    test_gaps();
    test_clear();
    test_rst_mid();
    test_back_to_back();
`ifdef PEAK_THRESH_EN
    test_thresh();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
